// File: rtl/segre_pkg.sv
// Shared constants and types for the segre memory subsystem.
// The main-memory defaults match the data-cache lane geometry.
package segre_pkg;

   localparam int ADDR_SIZE        = 32;
   localparam int DCACHE_LANE_SIZE = 128;
   localparam int MM_LANES         = 1024;
   localparam int MM_LATENCY       = 4;

   typedef enum logic [1:0] {
      MM_IDLE,
      MM_BUSY,
      MM_RESP
   } mm_state_e;

   typedef logic [$clog2(MM_LANES)-1:0] mm_index_t;

endpackage

// File: rtl/segre_mm_array.sv
// Lane storage: synchronous write, registered read.
// Only the read register is reset; the stored lanes survive reset.
module segre_mm_array #(
   parameter int DEPTH = 1024,
   parameter int WIDTH = 128
) (
   input  logic                     clk_i,
   input  logic                     rsn_i,
   input  logic                     we_i,
   input  logic                     re_i,
   input  logic [$clog2(DEPTH)-1:0] idx_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[idx_i] <= wdata_i;
      end
   end

   // Read data is held until the next read so the lane output stays stable.
   always_ff @(posedge clk_i) begin
      if (!rsn_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[idx_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/segre_main_memory.sv
// Lane-granular main memory behind the MMU: one request at a time, fixed latency,
// one-cycle ready pulse in the cycle that ends LATENCY edges after the request sample.
module segre_main_memory #(
   parameter int ADDR_SIZE = segre_pkg::ADDR_SIZE,
   parameter int LANE_SIZE = segre_pkg::DCACHE_LANE_SIZE,
   parameter int MEM_LANES = segre_pkg::MM_LANES,
   parameter int LATENCY   = segre_pkg::MM_LATENCY
) (
   input  logic                 clk_i,
   input  logic                 rsn_i,
   input  logic                 rd_req_i,
   input  logic                 wr_req_i,
   input  logic [ADDR_SIZE-1:0] addr_i,
   input  logic [LANE_SIZE-1:0] data_i,
   output logic                 data_rdy_o,
   output logic [LANE_SIZE-1:0] data_o,
   output logic                 busy_o
);
   import segre_pkg::*;

   localparam int IDX_W = $clog2(MEM_LANES);
   localparam int CNT_W = $clog2(LATENCY + 1);

   mm_state_e            state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 op_wr_q, op_wr_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [LANE_SIZE-1:0] wdata_q, wdata_d;
   logic                 commit;
   logic                 mem_we, mem_re;

   // Byte offset and bits above the lane index do not select storage.
   logic unused_addr;
   assign unused_addr = ^{addr_i[3:0], addr_i[ADDR_SIZE-1:IDX_W+4]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_wr_d = op_wr_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      commit  = 1'b0;
      case (state_q)
         MM_IDLE: begin
            if (rd_req_i || wr_req_i) begin
               op_wr_d = wr_req_i;
               idx_d   = addr_i[IDX_W+3:4];
               wdata_d = data_i;
               cnt_d   = CNT_W'(LATENCY - 1);
               if (LATENCY == 1) begin
                  state_d = MM_RESP;
                  commit  = 1'b1;
               end else begin
                  state_d = MM_BUSY;
               end
            end
         end
         MM_BUSY: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = MM_RESP;
               commit  = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         MM_RESP: begin
            state_d = MM_IDLE;
         end
         default: begin
            state_d = MM_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rsn_i) begin
         state_q <= MM_IDLE;
         cnt_q   <= '0;
         op_wr_q <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_wr_q <= op_wr_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
      end
   end

   // The _d operands let the single-cycle configuration commit straight from IDLE;
   // gating with rsn_i drops any write caught by a reset.
   assign mem_we = commit && op_wr_d && rsn_i;
   assign mem_re = commit && !op_wr_d && rsn_i;

   segre_mm_array #(
      .DEPTH (MEM_LANES),
      .WIDTH (LANE_SIZE)
   ) u_array (
      .clk_i   (clk_i),
      .rsn_i   (rsn_i),
      .we_i    (mem_we),
      .re_i    (mem_re),
      .idx_i   (idx_d),
      .wdata_i (wdata_d),
      .rdata_o (data_o)
   );

   assign data_rdy_o = (state_q == MM_RESP);
   assign busy_o     = (state_q != MM_IDLE);

endmodule

// File: tb/tb_segre_main_memory.sv
// Randomised bench for segre_main_memory against a lane-array reference model.
module tb_segre_main_memory;

   localparam int LAT   = 4;
   localparam int LANES = 1024;

   logic         clk;
   logic         rsn;
   logic         rd_req;
   logic         wr_req;
   logic [31:0]  addr;
   logic [127:0] data_in;
   logic         data_rdy_o;
   logic [127:0] data_o;
   logic         busy_o;

   int n_checks = 0;
   int n_fails  = 0;

   logic [127:0] model [int];
   logic [127:0] last_rd;
   bit           last_rd_known;

   segre_main_memory #(
      .ADDR_SIZE (32),
      .LANE_SIZE (128),
      .MEM_LANES (LANES),
      .LATENCY   (LAT)
   ) dut (
      .clk_i      (clk),
      .rsn_i      (rsn),
      .rd_req_i   (rd_req),
      .wr_req_i   (wr_req),
      .addr_i     (addr),
      .data_i     (data_in),
      .data_rdy_o (data_rdy_o),
      .data_o     (data_o),
      .busy_o     (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic int lane_of(input logic [31:0] a);
      return int'(a / 32'd16) % LANES;
   endfunction

   // One request, held until the requester sees ready, released at the following edge.
   task automatic do_op(input bit rd, input bit wr, input logic [31:0] a, input logic [127:0] d);
      int lat;
      int ln;
      ln = lane_of(a);
      @(negedge clk);
      rd_req = rd; wr_req = wr; addr = a; data_in = d;
      @(posedge clk);
      @(negedge clk);
      addr    = $urandom;
      data_in = {$urandom, $urandom, $urandom, $urandom};
      lat = -1;
      for (int c = 0; c <= LAT + 4; c++) begin
         if (c > 0) @(negedge clk);
         if (data_rdy_o) begin
            lat = c;
            break;
         end
         check_eq("busy_inflight", 128'(busy_o), 128'(1'b1));
      end
      check_eq("ready_edges", 128'(lat + 1), 128'(LAT));
      if (lat >= 0) begin
         check_eq("busy_resp", 128'(busy_o), 128'(1'b1));
         if (wr) begin
            model[ln] = d;
            if (last_rd_known) check_eq("data_hold_on_write", data_o, last_rd);
         end else if (model.exists(ln)) begin
            check_eq("read_data", data_o, model[ln]);
            last_rd = model[ln];
            last_rd_known = 1'b1;
         end else begin
            last_rd_known = 1'b0;
         end
      end
      @(posedge clk);
      @(negedge clk);
      rd_req = 1'b0; wr_req = 1'b0;
      check_eq("no_double_accept", 128'(data_rdy_o), 128'(1'b0));
      check_eq("busy_after_resp", 128'(busy_o), 128'(1'b0));
      @(posedge clk);
      @(negedge clk);
      check_eq("idle_no_ready", 128'(data_rdy_o), 128'(1'b0));
      $display("op rd=%0b wr=%0b addr=%h lane=%0d data=%h latency_edges=%0d", rd, wr, a, ln, d, lat + 1);
   endtask

   // Read held continuously: pulses repeat every LAT+1 cycles.
   task automatic stream_read(input logic [31:0] a);
      bit exp;
      int ln;
      ln = lane_of(a);
      @(negedge clk);
      rd_req = 1'b1; wr_req = 1'b0; addr = a;
      @(posedge clk);
      for (int c = 0; c <= 2 * LAT + 1; c++) begin
         @(negedge clk);
         exp = (c >= LAT - 1) && (((c - (LAT - 1)) % (LAT + 1)) == 0);
         check_eq("stream_ready", 128'(data_rdy_o), 128'(exp));
      end
      rd_req = 1'b0;
      if (model.exists(ln)) begin
         check_eq("stream_data", data_o, model[ln]);
         last_rd = model[ln];
         last_rd_known = 1'b1;
      end else begin
         last_rd_known = 1'b0;
      end
      @(negedge clk);
      $display("stream addr=%h lane=%0d", a, ln);
   endtask

   initial begin
      logic [31:0]  ra;
      logic [127:0] rd_v;
      int           kind;

      rsn = 1'b0; rd_req = 1'b0; wr_req = 1'b0; addr = '0; data_in = '0;
      repeat (4) begin
         @(posedge clk);
         @(negedge clk);
         check_eq("reset_ready", 128'(data_rdy_o), 128'(1'b0));
         check_eq("reset_busy", 128'(busy_o), 128'(1'b0));
         check_eq("reset_data", data_o, 128'h0);
      end
      rsn = 1'b1;
      last_rd = '0;
      last_rd_known = 1'b1;
      $display("reset released");

      do_op(1'b1, 1'b0, 32'h0000_0040, 128'h0);
      do_op(1'b0, 1'b1, 32'h0000_0120, 128'hff_ee_dd_cc_bb_aa_99_88_77_66_55_44_33_22_11_00);
      do_op(1'b1, 1'b0, 32'h0000_012C, 128'h0);
      do_op(1'b0, 1'b1, 32'h0000_4010, 128'hcafe_cafe);
      do_op(1'b1, 1'b0, 32'h0000_0010, 128'h0);
      do_op(1'b1, 1'b1, 32'h0000_0080, 128'h1);
      do_op(1'b1, 1'b0, 32'h0000_0080, 128'h0);
      stream_read(32'h0000_0120);

      // Abort a write with reset before it reaches the response cycle.
      do_op(1'b0, 1'b1, 32'h0000_0200, 128'h5a5a_1234_5a5a_1234);
      @(negedge clk);
      wr_req = 1'b1; addr = 32'h0000_0200; data_in = 128'hdead;
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      rsn = 1'b0; wr_req = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check_eq("midop_reset_ready", 128'(data_rdy_o), 128'(1'b0));
         check_eq("midop_reset_busy", 128'(busy_o), 128'(1'b0));
         check_eq("midop_reset_data", data_o, 128'h0);
      end
      rsn = 1'b1;
      last_rd = '0;
      last_rd_known = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check_eq("post_reset_no_ready", 128'(data_rdy_o), 128'(1'b0));
      end
      $display("reset mid-op applied at lane %0d", lane_of(32'h200));
      do_op(1'b1, 1'b0, 32'h0000_0200, 128'h0);

      for (int i = 0; i < 30; i++) begin
         ra   = ($urandom & 32'hFFFF_C000) | ((32'h300 + 32'($urandom_range(0, 7))) << 4) | ($urandom & 32'hF);
         rd_v = {$urandom, $urandom, $urandom, $urandom};
         kind = $urandom_range(0, 2);
         case (kind)
            0:       do_op(1'b1, 1'b0, ra, rd_v);
            1:       do_op(1'b0, 1'b1, ra, rd_v);
            default: do_op(1'b1, 1'b1, ra, rd_v);
         endcase
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
